uart_rx_framer: RTL and testbench

Parametrised UART receive front end that replaces the fixed 8N1 receiver path feeding the enigma FSM. It synchronises the rxd pin and votes three samples at each mid-bit. Data width, parity and stop-bit count are configurable at build time. It flags framing, parity, break and overrun conditions and buffers received characters in a small FWFT FIFO with a valid/ready handshake. It sits between the board rxd pin and the command FSM.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_fifo.sv | 71 +++++++
 rtl/uart_rx_framer.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx_framer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants, FSM state encoding and a width helper for the UART receive path.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START      = 3'd1,
    ST_DATA       = 3'd2,
    ST_PARITY     = 3'd3,
    ST_STOP       = 3'd4,
    ST_BREAK_WAIT = 3'd5
  } rx_state_e;

  // Ceiling log2, used to size pointers, counters and the bit timer.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO holding received characters plus their error flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   rd_ready,
  output logic [WIDTH-1:0]       rdata,
  output logic                   valid,
  output logic [clog2(DEPTH):0]  count,
  output logic                   overflow
);
  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full, pop, wr_en;

  // Handshake decode: a full FIFO still accepts a write when the head leaves in the same cycle.
  always_comb begin
    full     = (count_q == (AW+1)'(DEPTH));
    valid    = (count_q != '0);
    pop      = valid & rd_ready;
    wr_en    = push & (~full | pop);
    overflow = push & full & ~pop;
    rdata    = valid ? mem_q[rd_ptr_q] : '0;
    count    = count_q;
  end

  // Storage write, pointer advance (natural wrap, depth is a power of two) and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_framer.sv
// UART receiver: rxd synchroniser, mid-bit 3-sample vote, framing FSM and character FIFO.
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rxd,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_frame_err,
  output logic                          rx_parity_err,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [clog2(FIFO_DEPTH):0]    fifo_count,
  output logic                          overrun,
  output logic                          break_det,
  output logic                          busy
);
  localparam int TW  = clog2(CLKS_PER_BIT);
  localparam int BW  = clog2(DATA_BITS + 1);
  localparam int MID = CLKS_PER_BIT / 2;
  localparam int EW  = DATA_BITS + 2;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  rx_state_e              state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   s0_q, s0_d, s1_q, s1_d;
  logic                   par_err_q, par_err_d;
  logic                   frm_err_q, frm_err_d;
  logic                   zero_q, zero_d;
  logic                   brk_q, brk_d;
  logic                   ovr_q, ovr_d;
  logic                   synced, fall, dec, vote;
  logic                   last_stop, is_brk, push, fifo_ovf, exp_par;
  logic [EW-1:0]          push_word, head_word;

  // Synchroniser shift, falling-edge detect and majority of the three mid-bit samples.
  always_comb begin
    synced = sync_q[SYNC_STAGES-1];
    sync_d = {sync_q[SYNC_STAGES-2:0], rxd};
    hist_d = synced;
    fall   = hist_q & ~synced;
    s0_d   = (timer_q == TW'(MID - 1)) ? synced : s0_q;
    s1_d   = (timer_q == TW'(MID)) ? synced : s1_q;
    dec    = (timer_q == TW'(MID + 1)) &&
             (state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP});
    vote   = (s0_q & s1_q) | (s0_q & synced) | (s1_q & synced);
  end

  // Next-state and frame accumulation; timer only restarts when leaving IDLE so bit decisions stay one bit apart.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    zero_d    = zero_q;
    if (state_q == ST_IDLE || state_q == ST_BREAK_WAIT) timer_d = '0;
    else if (timer_q == TW'(CLKS_PER_BIT - 1))         timer_d = '0;
    else                                                timer_d = timer_q + 1'b1;
    case (state_q)
      ST_IDLE: if (fall) state_d = ST_START;
      ST_START: begin
        if (dec) begin
          if (vote) state_d = ST_IDLE;
          else begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
            par_err_d = 1'b0;
            frm_err_d = 1'b0;
            zero_d    = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (dec) begin
          shift_d = {vote, shift_q[DATA_BITS-1:1]};
          zero_d  = zero_q & ~vote;
          if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (dec) begin
          par_err_d = (vote != exp_par);
          zero_d    = zero_q & ~vote;
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (dec) begin
          frm_err_d = frm_err_q | ~vote;
          zero_d    = zero_q & ~vote;
          if (last_stop) state_d = is_brk ? ST_BREAK_WAIT : ST_IDLE;
          else           bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      ST_BREAK_WAIT: if (synced) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: busy, end-of-frame push versus break pulse, and the packed FIFO entry.
  always_comb begin
    busy          = (state_q != ST_IDLE);
    exp_par       = (PARITY == PARITY_EVEN) ? ^shift_q : ~^shift_q;
    last_stop     = (state_q == ST_STOP) && dec && (bit_cnt_q == BW'(STOP_BITS - 1));
    is_brk        = zero_q & ~vote;
    push          = last_stop & ~is_brk;
    brk_d         = last_stop & is_brk;
    ovr_d         = fifo_ovf;
    push_word     = {par_err_q, frm_err_q | ~vote, shift_q};
    rx_data       = head_word[DATA_BITS-1:0];
    rx_frame_err  = head_word[DATA_BITS];
    rx_parity_err = head_word[DATA_BITS+1];
    overrun       = ovr_q;
    break_det     = brk_q;
  end

  // State register for synchroniser, FSM, timer and frame accumulators.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '1;
      hist_q    <= 1'b1;
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      s0_q      <= 1'b0;
      s1_q      <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      zero_q    <= 1'b0;
      brk_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      hist_q    <= hist_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      zero_q    <= zero_d;
      brk_q     <= brk_d;
      ovr_q     <= ovr_d;
    end
  end

  uart_rx_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .wdata    (push_word),
    .rd_ready (rx_ready),
    .rdata    (head_word),
    .valid    (rx_valid),
    .count    (fifo_count),
    .overflow (fifo_ovf)
  );

endmodule

// File: tb/tb_uart_rx_framer.sv
// Bench for uart_rx_framer: an 8N1 instance at 104 clk/bit and an 8E2 instance at 16 clk/bit.
module tb_uart_rx_framer;
  import uart_pkg::*;

  localparam int CPB_A = 104;
  localparam int CPB_B = 16;
  localparam int SYNC  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rxd_a = 1'b1, rxd_b = 1'b1, rdy_a = 1'b1, rdy_b = 1'b1;
  logic [7:0] a_data, b_data;
  logic a_ferr, a_perr, a_valid, a_ovr, a_brk, a_busy;
  logic b_ferr, b_perr, b_valid, b_ovr, b_brk, b_busy;
  logic [2:0] a_cnt, b_cnt;

  int cyc = 0;
  int n_cmp = 0, n_bad = 0;
  int brk_a = 0, brk_b = 0, ovr_a = 0, ovr_b = 0;
  int exp_brk_a = 0, exp_brk_b = 0;
  int vcyc_a = 0, vrise_a = -1, start_a = 0;
  logic pv_a = 1'b0;
  bit rand_rdy = 1'b0;
  logic [9:0] q_a[$];
  logic [9:0] q_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_framer #(.CLKS_PER_BIT(CPB_A), .DATA_BITS(8), .PARITY(PARITY_NONE), .STOP_BITS(1),
                   .FIFO_DEPTH(4), .SYNC_STAGES(SYNC)) dut_a (
    .clk(clk), .rst(rst), .rxd(rxd_a), .rx_data(a_data), .rx_frame_err(a_ferr),
    .rx_parity_err(a_perr), .rx_valid(a_valid), .rx_ready(rdy_a), .fifo_count(a_cnt),
    .overrun(a_ovr), .break_det(a_brk), .busy(a_busy));

  uart_rx_framer #(.CLKS_PER_BIT(CPB_B), .DATA_BITS(8), .PARITY(PARITY_EVEN), .STOP_BITS(2),
                   .FIFO_DEPTH(4), .SYNC_STAGES(SYNC)) dut_b (
    .clk(clk), .rst(rst), .rxd(rxd_b), .rx_data(b_data), .rx_frame_err(b_ferr),
    .rx_parity_err(b_perr), .rx_valid(b_valid), .rx_ready(rdy_b), .fifo_count(b_cnt),
    .overrun(b_ovr), .break_det(b_brk), .busy(b_busy));

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, got, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Reference model: expected entry derived from the frame fields, then the line is driven bit by bit.
  task automatic send_frame(input int i, input logic [7:0] d, input logic pbit,
                            input logic [1:0] stops, input bit push_exp);
    logic [11:0] bits;
    logic [9:0]  e;
    int n, ns, cpb;
    bit has_par, frm, par, brk;
    has_par = (i == 1);
    ns      = (i == 1) ? 2 : 1;
    cpb     = (i == 1) ? CPB_B : CPB_A;
    bits    = '0;
    for (int k = 0; k < 8; k++) bits[1+k] = d[k];
    n = 9;
    if (has_par) begin bits[n] = pbit; n++; end
    frm = 1'b0;
    for (int s = 0; s < ns; s++) begin
      bits[n] = stops[s];
      n++;
      if (!stops[s]) frm = 1'b1;
    end
    par = has_par && (pbit != (^d));
    brk = (d == 8'h00) && (!has_par || !pbit) && ((ns == 1) ? !stops[0] : (stops == 2'b00));
    e   = {par, frm, d};
    if (brk) begin
      if (i == 0) exp_brk_a++; else exp_brk_b++;
    end else if (push_exp) begin
      if (i == 0) q_a.push_back(e); else q_b.push_back(e);
    end
    for (int k = 0; k < n; k++) begin
      if (i == 0) begin
        rxd_a = bits[k];
        if (k == 0) start_a = cyc;
      end else begin
        rxd_b = bits[k];
      end
      ticks(cpb);
    end
    if (i == 0) rxd_a = 1'b1; else rxd_b = 1'b1;
    ticks(2 * cpb);
  endtask

  task automatic drain(input int i);
    for (int k = 0; k < 3000; k++) begin
      if ((i == 0 ? q_a.size() : q_b.size()) == 0) break;
      tick();
    end
    ticks(4);
  endtask

  // Monitor for instance A: pulse counters, valid timing, and pop/compare on each accepted entry.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (a_brk === 1'b1) brk_a++;
      if (a_ovr === 1'b1) ovr_a++;
      if (a_valid === 1'b1) vcyc_a++;
      if (a_valid === 1'b1 && pv_a !== 1'b1 && vrise_a < 0) vrise_a = cyc;
      pv_a = a_valid;
      if (a_valid === 1'b1 && rdy_a === 1'b1) begin
        if (q_a.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL a_unexpected_pop: got %0h required no entry", a_data);
        end else begin
          e = q_a.pop_front();
          check("a_data", a_data, e[7:0]);
          check("a_frame_err", a_ferr, e[8]);
          check("a_parity_err", a_perr, e[9]);
        end
      end
    end
  end

  // Monitor for instance B.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (b_brk === 1'b1) brk_b++;
      if (b_ovr === 1'b1) ovr_b++;
      if (b_valid === 1'b1 && rdy_b === 1'b1) begin
        if (q_b.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL b_unexpected_pop: got %0h required no entry", b_data);
        end else begin
          e = q_b.pop_front();
          check("b_data", b_data, e[7:0]);
          check("b_frame_err", b_ferr, e[8]);
          check("b_parity_err", b_perr, e[9]);
        end
      end
    end
  end

  // Random consumer back-pressure for instance B.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) rdy_b = ($urandom_range(0, 1) == 1);
    end
  end

  // Watchdog.
  initial begin
    #(90000 * 10);
    n_bad++;
    $display("FAIL watchdog: got timeout required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    logic [7:0] d, t;
    logic pb;
    logic [1:0] st;
    int k;
    #1 rst = 1'b1;
    ticks(3);
    check("rst_valid", a_valid, 1'b0);
    check("rst_data", a_data, 8'h00);
    check("rst_count", a_cnt, 3'd0);
    check("rst_busy", a_busy, 1'b0);
    check("rst_ovr", a_ovr, 1'b0);
    check("rst_brk", a_brk, 1'b0);
    check("rst_errs", {a_ferr, a_perr, b_ferr, b_perr}, 4'h0);
    rst = 1'b0;
    ticks(3);
    check("post_rst_busy_b", b_busy, 1'b0);
    check("post_rst_count_b", b_cnt, 3'd0);

    // 1: basic 8N1 character and latency
    send_frame(0, 8'h41, 1'b0, 2'b11, 1'b1);
    check("t1_latency", vrise_a - start_a, SYNC + 3 + CPB_A / 2 + 9 * CPB_A);
    check("t1_valid_cycles", vcyc_a, 1);
    check("t1_busy_idle", a_busy, 1'b0);
    check("t1_queue_empty", q_a.size(), 0);

    // 2: even parity, wrong then right parity bit
    send_frame(1, 8'h41, 1'b1, 2'b11, 1'b1);
    send_frame(1, 8'h43, 1'b1, 2'b11, 1'b1);
    check("t2_queue_empty", q_b.size(), 0);

    // 3: low stop bit on both instances
    send_frame(0, 8'h55, 1'b0, 2'b00, 1'b1);
    check("t3_no_break", brk_a, exp_brk_a);
    t = 8'hA7;
    send_frame(1, t, ^t, 2'b01, 1'b1);
    check("t3_b_queue_empty", q_b.size(), 0);

    // 4: short glitch is a false start
    rxd_a = 1'b0;
    ticks(20);
    check("t4_busy_during", a_busy, 1'b1);
    rxd_a = 1'b1;
    k = 0;
    while (a_busy && k < CPB_A / 2 + 2 + SYNC) begin tick(); k++; end
    check("t4_busy_cleared", a_busy, 1'b0);
    ticks(2 * CPB_A);
    check("t4_count", a_cnt, 3'd0);
    check("t4_no_break", brk_a, exp_brk_a);

    // 5: break then recovery
    rxd_a = 1'b0;
    ticks(12 * CPB_A);
    rxd_a = 1'b1;
    ticks(2 * CPB_A);
    exp_brk_a++;
    check("t5_break_once", brk_a, exp_brk_a);
    check("t5_count", a_cnt, 3'd0);
    send_frame(0, 8'h5A, 1'b0, 2'b11, 1'b1);
    check("t5_queue_empty", q_a.size(), 0);

    // 6: fill FIFO with consumer stalled, fifth frame overruns
    rdy_a = 1'b0;
    for (int j = 1; j <= 5; j++) send_frame(0, 8'(j), 1'b0, 2'b11, j <= 4);
    check("t6_count_full", a_cnt, 3'd4);
    check("t6_overrun_once", ovr_a, 1);
    rdy_a = 1'b1;
    drain(0);
    check("t6_drained", q_a.size(), 0);
    check("t6_count_empty", a_cnt, 3'd0);

    // Reset in the middle of a frame with a character pending
    rdy_a = 1'b0;
    send_frame(0, 8'h33, 1'b0, 2'b11, 1'b0);
    check("rm_count_before", a_cnt, 3'd1);
    rxd_a = 1'b0;
    ticks(3 * CPB_A);
    check("rm_busy_before", a_busy, 1'b1);
    rst = 1'b1;
    #1;
    check("rm_valid", a_valid, 1'b0);
    check("rm_data", a_data, 8'h00);
    check("rm_count", a_cnt, 3'd0);
    check("rm_busy", a_busy, 1'b0);
    check("rm_flags", {a_ferr, a_perr, a_ovr, a_brk}, 4'h0);
    ticks(2);
    rxd_a = 1'b1;
    rst = 1'b0;
    ticks(2 * CPB_A);
    rdy_a = 1'b1;
    send_frame(0, 8'h7E, 1'b0, 2'b11, 1'b1);
    drain(0);
    check("rm_after_queue", q_a.size(), 0);

    // Randomised frames on the parity/two-stop instance
    rand_rdy = 1'b1;
    for (int j = 0; j < 30; j++) begin
      d  = 8'($urandom_range(0, 255));
      pb = (^d) ^ ($urandom_range(0, 3) == 0);
      st = {($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0)};
      if ($urandom_range(0, 9) == 0) begin d = 8'h00; pb = 1'b0; st = 2'b00; end
      send_frame(1, d, pb, st, 1'b1);
    end
    rand_rdy = 1'b0;
    tick();
    rdy_b = 1'b1;
    drain(1);

    check("end_b_queue", q_b.size(), 0);
    check("end_b_breaks", brk_b, exp_brk_b);
    check("end_b_overrun", ovr_b, 0);
    check("end_a_breaks", brk_a, exp_brk_a);
    check("end_a_overrun", ovr_a, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
